axis_pkt_rr_arbiter: RTL
========================

# axis_pkt_rr_arbiter

Packet-granular round-robin arbiter that shares one AXI-Stream sink, normally the input of `axis_ping_pong_buffer`, between `NUM_SRC` upstream requesters. A grant is held from the first beat to the `tlast` beat of a packet, so packets from different sources never interleave. Fairness is round-robin over sources, and each arbitration decision costs one idle cycle. An optional beat limit keeps any packet from exceeding the downstream buffer depth.

## Interface
- `NUM_SRC`, 4: number of requesters, 2..16.
- `DATA_WIDTH`, 64: beat width in bits.
- `MAX_BEATS`, 64: packet beat limit, used only with `AXIS_ARB_MAXLEN_EN`; set it equal to the buffer `MAX_DEPTH`.
- `IDW`: local parameter, `$clog2(NUM_SRC)`.
- `clk` in 1: the only clock; all logic is on the rising edge.
- `rst_n` in 1: asynchronous active-low reset.
- `s_axis_tdata` in `NUM_SRC*DATA_WIDTH`: source i occupies bits `[i*DATA_WIDTH +: DATA_WIDTH]`.
- `s_axis_tvalid` in `NUM_SRC`: per-source valid.
- `s_axis_tlast` in `NUM_SRC`: per-source last.
- `s_axis_tready` out `NUM_SRC`: per-source ready.
- `m_axis_tdata` out `DATA_WIDTH`: data to the shared sink.
- `m_axis_tvalid` out 1: valid to the shared sink.
- `m_axis_tlast` out 1: last to the shared sink.
- `m_axis_tready` in 1: ready from the shared sink.
- `grant_valid` out 1: high while a source holds the grant.
- `grant_id` out `IDW`: index of the current or most recent grantee.

## Operation
- FSM states: `IDLE`, `BUSY`. Registered state: `state`, `grant_id`, `last_grant` (`IDW` bits), `beat_cnt` (macro only).
- `IDLE`:
  - All `s_axis_tready` = 0, `m_axis_tvalid` = 0, `m_axis_tlast` = 0, `m_axis_tdata` = 0.
  - When any `s_axis_tvalid` bit is 1, pick the first asserted source searching from `last_grant+1` upward with modulo-`NUM_SRC` wrap.
  - Register the pick into `grant_id` and go to `BUSY`.
- `BUSY`, datapath is combinational pass-through of source g = `grant_id`:
  - `m_axis_tdata` = `s_axis_tdata[g]`.
  - `m_axis_tvalid` = `s_axis_tvalid[g]`.
  - `m_axis_tlast` = `s_axis_tlast[g]`.
  - `s_axis_tready[g]` = `m_axis_tready`; every other `s_axis_tready` bit = 0.
- Packet end: a handshake (`m_axis_tvalid && m_axis_tready`) with `m_axis_tlast` = 1 sets `last_grant` <= g and returns the FSM to `IDLE`.
- Stall: the grantee deasserting `tvalid` mid-packet keeps the grant. There is no timeout; the arbiter waits indefinitely.
- Valid edge case: a source that drops `tvalid` between the `IDLE` pick and `BUSY` keeps the grant. `BUSY` waits for it.
- Single requester: it wins every arbitration. Throughput is L beats per L+1 cycles for an L-beat packet.
- `grant_valid` = (`state` == `BUSY`).

## Timing
- Reset values:
  - `state` = `IDLE`, `grant_id` = 0, `last_grant` = `NUM_SRC-1` (source 0 has first priority), `beat_cnt` = 0.
  - All outputs 0.
- Reset asserted mid-packet aborts immediately: outputs go to 0 and the partial packet is dropped from the arbiter's view. The sink must be reset together with the arbiter.
- Arbitration latency: `tvalid` seen in `IDLE` at cycle N; first beat can handshake at cycle N+1.
- Back-to-back: the `tlast` handshake at cycle N is followed by `IDLE` at N+1 and the next grant's first beat at N+2.
- The pass-through path is combinational from `s_axis_*` and `m_axis_tready` to `m_axis_*` and `s_axis_tready`, with no added latency. Insert a register slice outside this block if timing requires it.
- `m_axis_tvalid` never depends on `m_axis_tready`.

## Configuration
- Macro: `AXIS_ARB_MAXLEN_EN`.
- Defined:
  - `beat_cnt` (`$clog2(MAX_BEATS+1)` bits) counts handshakes in `BUSY` and clears on return to `IDLE`.
  - On the handshake where `beat_cnt == MAX_BEATS-1`, `m_axis_tlast` is forced to 1 and the grant is released exactly as on a real `tlast`.
  - The source's remaining beats form a new packet and re-arbitrate normally.
  - Guarantees no packet exceeds `MAX_BEATS` beats.
- Undefined: no counter is built; packets pass with unlimited length and `tlast` comes only from the source.

## Test plan
- Reset, then hold all inputs idle for 10 cycles. Every output stays 0, and `grant_id` stays 0.
- Sources 0 and 2 both present 3-beat packets at the same cycle, with `m_axis_tready` = 1:
  - Source 0 is served first: beats at cycles 1–3 after the pick.
  - Source 2 follows: first beat 2 cycles after source 0's `tlast`.
  - `last_grant` ends at 2.
- All 4 sources request continuously with 1-beat packets. Grant order is 0,1,2,3,0,1…, one packet per 2 cycles.
- Source 1 sends 4 beats while `m_axis_tready` toggles 1,0,1,0, and source 1 drops `tvalid` for 2 cycles mid-packet:
  - No beat is lost or duplicated.
  - Source 3, requesting throughout, is not granted until source 1's `tlast`.
- With `AXIS_ARB_MAXLEN_EN` defined and `MAX_BEATS` = 64, source 0 sends 70 beats with `tlast` on beat 70 while source 1 also requests:
  - Output packet of 64 beats, with `tlast` on beat 64.
  - Source 1's packet follows.
  - Then source 0's 6-beat remainder.
- Assert `rst_n` = 0 during beat 2 of 5. Outputs go to 0 asynchronously. After release, source 0 is granted first on the next request.

Source files
------------

// File: rtl/axis_pkt_rr_arbiter_if.sv
// Bundle of AXI-Stream lanes sharing one tdata bus; LANES = 1 describes a
// single stream, LANES = N packs N independent streams side by side.
interface axis_pkt_rr_arbiter_if #(
    parameter int LANES      = 1,
    parameter int DATA_WIDTH = 64
);
    logic [LANES*DATA_WIDTH-1:0] tdata;
    logic [LANES-1:0]            tvalid;
    logic [LANES-1:0]            tlast;
    logic [LANES-1:0]            tready;

    modport master (output tdata, tvalid, tlast, input tready);
    modport slave  (input tdata, tvalid, tlast, output tready);
endinterface

// File: rtl/axis_pkt_rr_arbiter.sv
// Packet-granular round-robin arbiter sharing one AXI-Stream sink between
// NUM_SRC sources. Define AXIS_ARB_MAXLEN_EN to cap packets at MAX_BEATS beats.
module axis_pkt_rr_arbiter #(
    parameter  int NUM_SRC    = 4,
    parameter  int DATA_WIDTH = 64,
    parameter  int MAX_BEATS  = 64,
    localparam int IDW        = $clog2(NUM_SRC)
) (
    input  logic                     clk,
    input  logic                     rst_n,
    axis_pkt_rr_arbiter_if.slave     s_axis,
    axis_pkt_rr_arbiter_if.master    m_axis,
    output logic                     grant_valid,
    output logic [IDW-1:0]           grant_id
);

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    state_t         state, state_nxt;
    logic [IDW-1:0] last_grant, last_nxt, grant_nxt, pick;
    logic           any_req, hs, pkt_end, force_last;

    // Nearest requester strictly after `last`, wrapping modulo NUM_SRC.
    function automatic logic [IDW-1:0] rr_pick(input logic [NUM_SRC-1:0] req,
                                               input logic [IDW-1:0]     last);
        int idx;
        rr_pick = last;
        for (int k = NUM_SRC; k >= 1; k--) begin
            idx = (int'(last) + k) % NUM_SRC;
            if (req[idx]) rr_pick = idx[IDW-1:0];
        end
    endfunction

    assign any_req = |s_axis.tvalid;
    assign pick    = rr_pick(s_axis.tvalid, last_grant);
    assign hs      = m_axis.tvalid[0] & m_axis.tready[0];
    assign pkt_end = hs & m_axis.tlast[0];

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of process evaluation order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            grant_id   <= '0;
            last_grant <= IDW'(NUM_SRC - 1);
        end else begin
            state      <= state_nxt;
            grant_id   <= grant_nxt;
            last_grant <= last_nxt;
        end
    end

    // NOTE: every combinational output gets a default first, so no path can
    // leave a signal unassigned and infer a latch.
    always_comb begin
        state_nxt = state;
        grant_nxt = grant_id;
        last_nxt  = last_grant;
        case (state)
            IDLE: if (any_req) begin
                grant_nxt = pick;
                state_nxt = BUSY;
            end
            BUSY: if (pkt_end) begin
                last_nxt  = grant_id;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Pass-through of the grantee; the grant is held across source stalls.
    always_comb begin
        m_axis.tdata  = '0;
        m_axis.tvalid = '0;
        m_axis.tlast  = '0;
        s_axis.tready = '0;
        if (state == BUSY) begin
            m_axis.tdata           = s_axis.tdata[int'(grant_id)*DATA_WIDTH +: DATA_WIDTH];
            m_axis.tvalid[0]       = s_axis.tvalid[grant_id];
            m_axis.tlast[0]        = s_axis.tlast[grant_id] | force_last;
            s_axis.tready[grant_id] = m_axis.tready[0];
        end
    end

    assign grant_valid = (state == BUSY);

`ifdef AXIS_ARB_MAXLEN_EN
    localparam int CNT_W = $clog2(MAX_BEATS + 1);
    logic [CNT_W-1:0] beat_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)       beat_cnt <= '0;
        else if (pkt_end) beat_cnt <= '0;
        else if (hs)      beat_cnt <= beat_cnt + 1'b1;
    end

    // The beat that reaches the limit is closed as a packet end; the source's
    // remaining beats re-arbitrate as a fresh packet.
    assign force_last = (state == BUSY) && (beat_cnt == CNT_W'(MAX_BEATS - 1));
`else
    assign force_last = 1'b0;
`endif

endmodule
